// File: rtl/add_num_c1_wr_arbiter_if.sv
// Bundle of the requester-side write handshake and the CCI-P c1 TX/RX fields
// that the add-number AFU write arbiter sits between.
interface add_num_c1_wr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      c1_alm_full;
  logic                      c1_valid;
  logic [ADDR_W-1:0]         c1_addr;
  logic                      c1_sop;
  logic [15:0]               c1_mdata;
  logic [DATA_W-1:0]         c1_data;
  logic                      c1_rsp_valid;
  logic [15:0]               c1_rsp_mdata;
  logic [NUM_REQ-1:0]        req_done;
  logic [7:0]                outstanding;
  logic                      rsp_err;

  modport slave (
    input  req_valid, req_addr, req_data, c1_alm_full, c1_rsp_valid, c1_rsp_mdata,
    output req_ready, c1_valid, c1_addr, c1_sop, c1_mdata, c1_data,
           req_done, outstanding, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_data, c1_alm_full, c1_rsp_valid, c1_rsp_mdata,
    input  req_ready, c1_valid, c1_addr, c1_sop, c1_mdata, c1_data,
           req_done, outstanding, rsp_err
  );
endinterface

// File: rtl/add_num_c1_wr_arbiter.sv
// Round-robin arbiter sharing the CCI-P c1 write channel among NUM_REQ requesters.
// Define ADD_NUM_C1_WR_ARB_STATS_EN to add per-requester issue and stall counters.
module add_num_c1_wr_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = 42,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  add_num_c1_wr_arbiter_if.slave  bus
`ifdef ADD_NUM_C1_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]   stat_issued,
  output logic [31:0]             stat_stall
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   grant_s;
  logic               grant_vld_s;
  logic               can_issue_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               accept_s;
  logic               rsp_bad_s;
  logic               rsp_ok_s;
  logic [IDX_W-1:0]   rsp_idx_s;
  int                 idx_s;

  logic               c1_valid_r;
  logic [ADDR_W-1:0]  c1_addr_r;
  logic [DATA_W-1:0]  c1_data_r;
  logic [15:0]        c1_mdata_r;
  logic               c1_sop_r;
  logic [NUM_REQ-1:0] req_done_r;
  logic [7:0]         outstanding_r;
  logic               rsp_err_r;

  // Round-robin grant: walk offsets downward so the valid requester closest to ptr wins.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    idx_s       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_s = int'(ptr_r) + k;
      if (idx_s >= NUM_REQ) begin
        idx_s = idx_s - NUM_REQ;
      end else begin
        idx_s = idx_s;
      end
      if (bus.req_valid[idx_s]) begin
        grant_s     = IDX_W'(idx_s);
        grant_vld_s = 1'b1;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign can_issue_s = !bus.c1_alm_full && (outstanding_r < 8'(MAX_OUTSTANDING));

  // One-hot ready to the granted requester, suppressed while reset is asserted.
  always_comb begin
    ready_s = '0;
    if (!reset && can_issue_s && grant_vld_s) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign accept_s  = |ready_s;
  assign rsp_idx_s = bus.c1_rsp_mdata[IDX_W-1:0];
  // Any mdata beyond the requester range is bad, including nonzero upper bits.
  assign rsp_bad_s = bus.c1_rsp_valid &&
                     ((bus.c1_rsp_mdata >= 16'(NUM_REQ)) || (outstanding_r == 8'd0));
  assign rsp_ok_s  = bus.c1_rsp_valid && !rsp_bad_s;

  // c1 TX register stage and round-robin pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1_valid_r <= 1'b0;
      c1_addr_r  <= '0;
      c1_data_r  <= '0;
      c1_mdata_r <= 16'd0;
      c1_sop_r   <= 1'b0;
      ptr_r      <= '0;
    end else if (accept_s) begin
      c1_valid_r <= 1'b1;
      c1_addr_r  <= bus.req_addr[grant_s*ADDR_W +: ADDR_W];
      c1_data_r  <= bus.req_data[grant_s*DATA_W +: DATA_W];
      c1_mdata_r <= 16'(grant_s);
      c1_sop_r   <= 1'b1;
      ptr_r      <= (grant_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_s + IDX_W'(1);
    end else begin
      c1_valid_r <= 1'b0;
    end
  end

  // Outstanding-write counter, completion pulses and sticky response error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_r <= 8'd0;
      req_done_r    <= '0;
      rsp_err_r     <= 1'b0;
    end else begin
      case ({accept_s, rsp_ok_s})
        2'b10:   outstanding_r <= outstanding_r + 8'd1;
        2'b01:   outstanding_r <= outstanding_r - 8'd1;
        default: outstanding_r <= outstanding_r;
      endcase
      req_done_r <= '0;
      if (rsp_ok_s) begin
        req_done_r[rsp_idx_s] <= 1'b1;
      end
      if (rsp_bad_s) begin
        rsp_err_r <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.c1_valid    = c1_valid_r;
  assign bus.c1_addr     = c1_addr_r;
  assign bus.c1_data     = c1_data_r;
  assign bus.c1_mdata    = c1_mdata_r;
  assign bus.c1_sop      = c1_sop_r;
  assign bus.req_done    = req_done_r;
  assign bus.outstanding = outstanding_r;
  assign bus.rsp_err     = rsp_err_r;

`ifdef ADD_NUM_C1_WR_ARB_STATS_EN
  logic [31:0] issued_cnt_r [NUM_REQ];
  logic [31:0] stall_cnt_r;

  // Free-running wrap-around statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        issued_cnt_r[i] <= 32'd0;
      end
      stall_cnt_r <= 32'd0;
    end else begin
      if (accept_s) begin
        issued_cnt_r[grant_s] <= issued_cnt_r[grant_s] + 32'd1;
      end
      if ((|bus.req_valid) && !accept_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_issued[g*32 +: 32] = issued_cnt_r[g];
  end
  assign stat_stall = stall_cnt_r;
`endif

endmodule

// File: tb/tb_add_num_c1_wr_arbiter.sv
// Randomized and directed bench for add_num_c1_wr_arbiter against a cycle-level
// behavioural model of the arbitration, throttling and response rules.
module tb_add_num_c1_wr_arbiter;

  localparam int N    = 2;
  localparam int AW   = 42;
  localparam int DW   = 512;
  localparam int MAXO = 6;

  logic clk;
  logic reset;

  add_num_c1_wr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ADD_NUM_C1_WR_ARB_STATS_EN
  logic [N*32-1:0] stat_issued;
  logic [31:0]     stat_stall;
`endif

  add_num_c1_wr_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus)
`ifdef ADD_NUM_C1_WR_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run;
  int tests_failed;

  // Reference model state
  int            m_ptr;
  int            m_out;
  bit            m_err;
  logic [N-1:0]  m_done;
  logic [N-1:0]  m_ready;
  bit            m_c1_valid;
  bit            m_sop;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [15:0]   m_mdata;
  int unsigned   m_issued [N];
  int unsigned   m_stall;
  int            pend_q [$];

  task automatic chk_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_out = 0; m_err = 1'b0; m_done = '0;
    m_c1_valid = 1'b0; m_sop = 1'b0; m_addr = '0; m_data = '0; m_mdata = 16'd0;
    for (int i = 0; i < N; i++) m_issued[i] = 0;
    m_stall = 0;
    pend_q.delete();
  endtask

  // Expected ready from the rules: nearest valid requester at or after ptr, if issuing is allowed.
  task automatic calc_ready();
    bit can;
    int i;
    m_ready = '0;
    can = !bus.c1_alm_full && (m_out < MAXO);
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (bus.req_valid[i]) begin
          if (can) m_ready[i] = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic model_clock();
    int acc;
    acc = -1;
    for (int i = 0; i < N; i++) if (m_ready[i]) acc = i;
    m_done = '0;
    if (bus.c1_rsp_valid) begin
      if (int'(bus.c1_rsp_mdata) >= N || m_out == 0) m_err = 1'b1;
      else begin
        m_done[bus.c1_rsp_mdata] = 1'b1;
        m_out--;
      end
    end
    if (acc >= 0) begin
      m_out++;
      m_c1_valid = 1'b1;
      m_sop      = 1'b1;
      m_addr     = bus.req_addr[acc*AW +: AW];
      m_data     = bus.req_data[acc*DW +: DW];
      m_mdata    = 16'(acc);
      m_ptr      = (acc + 1) % N;
      m_issued[acc]++;
      pend_q.push_back(acc);
    end else begin
      m_c1_valid = 1'b0;
      if (|bus.req_valid) m_stall++;
    end
  endtask

  task automatic check_outputs();
    chk_val("c1_valid", bus.c1_valid, m_c1_valid);
    chk_val("c1_sop", bus.c1_sop, m_sop);
    chk_val("c1_addr", bus.c1_addr, m_addr);
    chk_val("c1_data", bus.c1_data, m_data);
    chk_val("c1_mdata", bus.c1_mdata, m_mdata);
    chk_val("req_done", bus.req_done, m_done);
    chk_val("outstanding", bus.outstanding, 8'(m_out));
    chk_val("rsp_err", bus.rsp_err, m_err);
`ifdef ADD_NUM_C1_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk_val("stat_issued", stat_issued[i*32 +: 32], m_issued[i]);
    chk_val("stat_stall", stat_stall, m_stall);
`endif
  endtask

  // Called right after a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1;
    calc_ready();
    chk_val("req_ready", bus.req_ready, m_ready);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic [N-1:0] v, input bit af, input bit rv, input logic [15:0] rm);
    bus.req_valid    = v;
    bus.c1_alm_full  = af;
    bus.c1_rsp_valid = rv;
    bus.c1_rsp_mdata = rm;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW] = {$urandom, $urandom};
      bus.req_data[i*DW +: DW] = rand_line();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk_val("rst_c1_valid", bus.c1_valid, 1'b0);
    chk_val("rst_c1_addr", bus.c1_addr, {AW{1'b0}});
    chk_val("rst_c1_data", bus.c1_data, {DW{1'b0}});
    chk_val("rst_c1_mdata", bus.c1_mdata, 16'd0);
    chk_val("rst_outstanding", bus.outstanding, 8'd0);
    chk_val("rst_rsp_err", bus.rsp_err, 1'b0);
    chk_val("rst_req_ready", bus.req_ready, {N{1'b0}});
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
  endtask

  int issues;
  logic [15:0] rm;
  bit          rv;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    drive('0, 1'b0, 1'b0, 16'd0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Single write and its response
    bus.req_addr[0 +: AW] = 42'h100;
    bus.req_data[0 +: DW] = 512'd50;
    drive(2'b01, 1'b0, 1'b0, 16'd0);
    step();
    chk_val("t2_valid", bus.c1_valid, 1'b1);
    chk_val("t2_addr", bus.c1_addr, 42'h100);
    chk_val("t2_data", bus.c1_data, 512'd50);
    chk_val("t2_mdata", bus.c1_mdata, 16'd0);
    chk_val("t2_out1", bus.outstanding, 8'd1);
    drive(2'b00, 1'b0, 1'b1, 16'd0);
    step();
    chk_val("t2_done", bus.req_done, 2'b01);
    chk_val("t2_out0", bus.outstanding, 8'd0);
    drive(2'b00, 1'b0, 1'b0, 16'd0);
    step();
    chk_val("t2_done_clr", bus.req_done, 2'b00);

    // Alternating grants with both requesters continuously valid
    do_reset();
    rand_payload();
    drive(2'b11, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_val("t3_order", bus.c1_mdata, 16'(k % 2));
    end
    chk_val("t3_out", bus.outstanding, 8'd6);
`ifdef ADD_NUM_C1_WR_ARB_STATS_EN
    chk_val("t3_stats", stat_issued, {32'd3, 32'd3});
`endif

    // Almost-full throttling
    do_reset();
    rand_payload();
    drive(2'b10, 1'b1, 1'b0, 16'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_val("t4_ready_af", bus.req_ready, 2'b00);
      step();
      chk_val("t4_valid_af", bus.c1_valid, 1'b0);
    end
    drive(2'b10, 1'b0, 1'b0, 16'd0);
    #1;
    chk_val("t4_ready_drop", bus.req_ready, 2'b10);
    step();
    chk_val("t4_issue", bus.c1_valid, 1'b1);
    chk_val("t4_mdata", bus.c1_mdata, 16'd1);

    // Outstanding limit
    do_reset();
    rand_payload();
    issues = 0;
    drive(2'b11, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < MAXO + 3; k++) begin
      step();
      if (bus.c1_valid) issues++;
    end
    chk_val("t5_issues", 32'(issues), 32'(MAXO));
    drive(2'b11, 1'b0, 1'b1, 16'(pend_q.pop_front()));
    step();
    chk_val("t5_no_issue_at_max", bus.c1_valid, 1'b0);
    drive(2'b11, 1'b0, 1'b0, 16'd0);
    step();
    chk_val("t5_one_more", bus.c1_valid, 1'b1);
    step();
    chk_val("t5_stall", bus.c1_valid, 1'b0);
    drive(2'b00, 1'b0, 1'b1, 16'(pend_q.pop_front()));
    step();
    drive(2'b11, 1'b0, 1'b1, 16'(pend_q.pop_front()));
    step();
    chk_val("t5_acc_rsp_same", bus.outstanding, 8'(MAXO - 1));

    // Error responses
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 16'd0);
    step();
    chk_val("t6_err_zero", bus.rsp_err, 1'b1);
    chk_val("t6_no_done", bus.req_done, 2'b00);
    do_reset();
    drive(2'b01, 1'b0, 1'b0, 16'd0);
    step();
    drive(2'b00, 1'b0, 1'b1, 16'd7);
    step();
    chk_val("t6_err_idx", bus.rsp_err, 1'b1);
    chk_val("t6_out_kept", bus.outstanding, 8'd1);
    drive(2'b00, 1'b0, 1'b0, 16'd0);
    step();
    chk_val("t6_sticky", bus.rsp_err, 1'b1);

    // Reset in the middle of traffic, then first grant goes to requester 0
    rand_payload();
    drive(2'b11, 1'b0, 1'b0, 16'd0);
    step();
    step();
    step();
    do_reset();
    drive(2'b11, 1'b0, 1'b0, 16'd0);
    step();
    chk_val("t1_first_grant", bus.c1_mdata, 16'd0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rand_payload();
      rv = 1'b0;
      rm = 16'd0;
      if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        rv = 1'b1;
        rm = 16'(pend_q.pop_front());
      end else if ($urandom_range(0, 29) == 0) begin
        rv = 1'b1;
        rm = 16'($urandom_range(0, 15));
      end
      drive(N'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), rv, rm);
      step();
      if (c % 150 == 149) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
